// File: rtl/wb_reg_file_pkg.sv
// Shared definitions for the writeback-stage register file.
//   DATA_WIDTH / ADDR_WIDTH / REG_COUNT : datapath and register-index sizing
//   ZERO_REG                            : hard-wired zero register index
//   WB_REG_WRITE / WB_MEM_TO_REG        : bit positions in the wbControl bus
//                                         carried by the pipeline registers
package wb_reg_file_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int REG_COUNT  = 2 ** ADDR_WIDTH;

  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;

  localparam addr_t ZERO_REG = '0;

  // wbControl = {regWrite, memToReg}
  localparam int WB_REG_WRITE  = 1;
  localparam int WB_MEM_TO_REG = 0;

  // Writeback source select: load data or ALU result.
  function automatic data_t wb_select(input logic  mem_to_reg,
                                      input data_t mem_data,
                                      input data_t alu_data);
    return mem_to_reg ? mem_data : alu_data;
  endfunction

endpackage

// File: rtl/wb_reg_file_if.sv
// Writeback / decode-side bus of the register file.
//   master : pipeline side (drives WB controls, write data and read indices)
//   slave  : wb_reg_file (returns operands, writeback value and write count)
interface wb_reg_file_if;
  import wb_reg_file_pkg::*;

  logic        regWrite;
  logic        memToReg;
  data_t       readDataMemory;
  data_t       aluResult;
  addr_t       writeRegister;
  addr_t       readRegister1;
  addr_t       readRegister2;
  data_t       readData1;
  data_t       readData2;
  data_t       writeBackData;
  logic [31:0] writeCount;

  modport master (
    output regWrite, memToReg, readDataMemory, aluResult,
    output writeRegister, readRegister1, readRegister2,
    input  readData1, readData2, writeBackData, writeCount
  );

  modport slave (
    input  regWrite, memToReg, readDataMemory, aluResult,
    input  writeRegister, readRegister1, readRegister2,
    output readData1, readData2, writeBackData, writeCount
  );

endinterface

// File: rtl/wb_reg_file_2r1w.sv
// reg_file_2r1w: 32 x 32-bit storage array, one write port, two raw
// combinational read ports, asynchronous clear.
//   clock, resetN      : clock and asynchronous active-low clear
//   we, waddr, wdata   : write port, committed on posedge
//   raddr1/2, rdata1/2 : raw read ports (no bypass, no zero masking here)
// Entry 0 is never written, so it stays at its reset value of zero.
module reg_file_2r1w
  import wb_reg_file_pkg::*;
(
  input  logic  clock,
  input  logic  resetN,
  input  logic  we,
  input  addr_t waddr,
  input  data_t wdata,
  input  addr_t raddr1,
  input  addr_t raddr2,
  output data_t rdata1,
  output data_t rdata2
);

  data_t regs [REG_COUNT];

  // NOTE: the array is reset because the whole file must clear instantly on
  // resetN; this makes it flops rather than a RAM macro, which is intended.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else if (we && waddr != ZERO_REG) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = regs[raddr1];
  assign rdata2 = regs[raddr2];

endmodule

// File: rtl/wb_reg_file.sv
// wb_reg_file: writeback stage. Selects the writeback value, commits it to the
// general-purpose register file and serves the two decode read ports with a
// same-cycle write-to-read bypass.
//   clock, resetN : clock and asynchronous active-low reset
//   bus (slave)   : WB controls, writeback data, read indices, operands,
//                   writeBackData (to forwarding unit), writeCount
module wb_reg_file
  import wb_reg_file_pkg::*;
(
  input  logic          clock,
  input  logic          resetN,
  wb_reg_file_if.slave  bus
);

  logic [1:0]  wb_control;
  logic        commit;
  data_t       wb_data;
  data_t       raw_data1;
  data_t       raw_data2;
  data_t       read_data1;
  data_t       read_data2;
  logic [31:0] write_count;

  assign wb_control[WB_REG_WRITE]  = bus.regWrite;
  assign wb_control[WB_MEM_TO_REG] = bus.memToReg;

  assign wb_data = wb_select(wb_control[WB_MEM_TO_REG], bus.readDataMemory, bus.aluResult);

  // Gating with resetN disables both the store and the bypass during reset,
  // so a write presented while in reset is dropped rather than deferred.
  assign commit = resetN && wb_control[WB_REG_WRITE] && (bus.writeRegister != ZERO_REG);

  reg_file_2r1w u_storage (
    .clock  (clock),
    .resetN (resetN),
    .we     (commit),
    .waddr  (bus.writeRegister),
    .wdata  (wb_data),
    .raddr1 (bus.readRegister1),
    .raddr2 (bus.readRegister2),
    .rdata1 (raw_data1),
    .rdata2 (raw_data2)
  );

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned and infers a latch.
  always_comb begin
    read_data1 = raw_data1;
    read_data2 = raw_data2;
    if (bus.readRegister1 == ZERO_REG)
      read_data1 = '0;
    else if (commit && bus.writeRegister == bus.readRegister1)
      read_data1 = wb_data;
    if (bus.readRegister2 == ZERO_REG)
      read_data2 = '0;
    else if (commit && bus.writeRegister == bus.readRegister2)
      read_data2 = wb_data;
  end

  // Counts commits to nonzero registers; wraps modulo 2**32.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN)     write_count <= '0;
    else if (commit) write_count <= write_count + 32'd1;
  end

  assign bus.readData1     = read_data1;
  assign bus.readData2     = read_data2;
  assign bus.writeBackData = wb_data;
  assign bus.writeCount    = write_count;

endmodule

// File: tb/tb_wb_reg_file.sv
// Directed bench for wb_reg_file: reset, writeback select, bypass, zero
// register, regWrite=0, back-to-back writes, counter wrap, mid-run reset.
module tb_wb_reg_file;
  import wb_reg_file_pkg::*;

  logic clock;
  logic resetN;
  int   checks;
  int   errors;

  wb_reg_file_if bus ();

  wb_reg_file dut (
    .clock  (clock),
    .resetN (resetN),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Present inputs on the falling edge, away from the active edge.
  task automatic drive(input logic rw, input logic m2r, input data_t mem,
                       input data_t alu, input addr_t wr, input addr_t rr1,
                       input addr_t rr2);
    @(negedge clock);
    bus.regWrite       = rw;
    bus.memToReg       = m2r;
    bus.readDataMemory = mem;
    bus.aluResult      = alu;
    bus.writeRegister  = wr;
    bus.readRegister1  = rr1;
    bus.readRegister2  = rr2;
    #1;
  endtask

  task automatic after_edge();
    @(posedge clock);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    resetN = 1'b0;
    bus.regWrite = 1'b0; bus.memToReg = 1'b0;
    bus.readDataMemory = '0; bus.aluResult = '0; bus.writeRegister = '0;
    bus.readRegister1 = 5'd1; bus.readRegister2 = 5'd2;
    repeat (2) @(posedge clock);
    #1;
    check("reset_rd1", bus.readData1, 32'h0);
    check("reset_count", bus.writeCount, 32'h0);

    @(negedge clock);
    resetN = 1'b1;

    // Writeback select: memory data to r3, bypassed on read port 1.
    drive(1'b1, 1'b1, 32'h1111_2222, 32'h3333_4444, 5'd3, 5'd3, 5'd0);
    check("wb_mem_sel", bus.writeBackData, 32'h1111_2222);
    check("wb_mem_bypass", bus.readData1, 32'h1111_2222);
    after_edge();
    check("count_1", bus.writeCount, 32'd1);

    // ALU result to r4; r3 now read from storage.
    drive(1'b1, 1'b0, 32'h1111_2222, 32'h3333_4444, 5'd4, 5'd3, 5'd4);
    check("wb_alu_sel", bus.writeBackData, 32'h3333_4444);
    check("r3_stored", bus.readData1, 32'h1111_2222);
    check("r4_bypass", bus.readData2, 32'h3333_4444);
    after_edge();
    check("count_2", bus.writeCount, 32'd2);

    drive(1'b0, 1'b0, '0, '0, 5'd0, 5'd3, 5'd4);
    check("r3_read", bus.readData1, 32'h1111_2222);
    check("r4_read", bus.readData2, 32'h3333_4444);

    // Both ports bypass the same write, then read it back from storage.
    drive(1'b1, 1'b0, 32'h0, 32'hCAFE_F00D, 5'd7, 5'd7, 5'd7);
    check("byp_rd1", bus.readData1, 32'hCAFE_F00D);
    check("byp_rd2", bus.readData2, 32'hCAFE_F00D);
    after_edge();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd7, 5'd7);
    check("r7_rd1", bus.readData1, 32'hCAFE_F00D);
    check("r7_rd2", bus.readData2, 32'hCAFE_F00D);
    check("count_3", bus.writeCount, 32'd3);

    // Write to the zero register is ignored.
    drive(1'b1, 1'b0, 32'h0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0);
    check("zero_pre", bus.readData1, 32'h0);
    check("zero_wbd", bus.writeBackData, 32'hFFFF_FFFF);
    after_edge();
    check("zero_post", bus.readData1, 32'h0);
    check("zero_count", bus.writeCount, 32'd3);

    // regWrite=0: no bypass, no store, no count.
    drive(1'b0, 1'b0, 32'h0, 32'h1234_5678, 5'd9, 5'd9, 5'd0);
    check("nowr_pre", bus.readData1, 32'h0);
    after_edge();
    check("nowr_post", bus.readData1, 32'h0);
    check("nowr_count", bus.writeCount, 32'd3);

    // Back-to-back writes to r10: last wins, each counts.
    drive(1'b1, 1'b0, 32'h0, 32'hAAAA_0001, 5'd10, 5'd10, 5'd0);
    after_edge();
    drive(1'b1, 1'b1, 32'hBBBB_0002, 32'h0, 5'd10, 5'd0, 5'd10);
    check("b2b_bypass", bus.readData2, 32'hBBBB_0002);
    after_edge();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd10, 5'd0);
    check("b2b_last", bus.readData1, 32'hBBBB_0002);
    check("b2b_count", bus.writeCount, 32'd5);

    // Counter wrap: preload to all-ones, next commit wraps to zero.
    force dut.write_count = 32'hFFFF_FFFF;
    #1;
    release dut.write_count;
    #1;
    check("wrap_preload", bus.writeCount, 32'hFFFF_FFFF);
    drive(1'b1, 1'b0, 32'h0, 32'h0000_0055, 5'd11, 5'd11, 5'd0);
    after_edge();
    check("wrap_count", bus.writeCount, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd11, 5'd0);
    check("wrap_r11", bus.readData1, 32'h0000_0055);

    // Mid-run reset clears state without a clock edge.
    drive(1'b1, 1'b0, 32'h0, 32'hDEAD_BEEF, 5'd5, 5'd5, 5'd0);
    after_edge();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd0);
    check("r5_written", bus.readData1, 32'hDEAD_BEEF);
    check("r5_count", bus.writeCount, 32'd1);
    resetN = 1'b0;
    #1;
    check("rst_async_rd1", bus.readData1, 32'h0);
    check("rst_async_count", bus.writeCount, 32'h0);

    // A write presented during reset is neither bypassed nor stored.
    drive(1'b1, 1'b0, 32'h0, 32'h0000_0077, 5'd5, 5'd5, 5'd0);
    check("rst_no_bypass", bus.readData1, 32'h0);
    after_edge();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd0);
    resetN = 1'b1;
    #1;
    check("rst_dropped", bus.readData1, 32'h0);
    check("rst_dropped_cnt", bus.writeCount, 32'h0);

    // First commit after reset release.
    drive(1'b1, 1'b0, 32'h0, 32'h0000_0066, 5'd6, 5'd6, 5'd0);
    after_edge();
    check("post_rst_count", bus.writeCount, 32'd1);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd6, 5'd0);
    check("post_rst_r6", bus.readData1, 32'h0000_0066);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
